proc_run_ctrl: RTL and testbench
================================

Name: proc_run_ctrl

Overview:
- Host-side initiator for the processor's Start/Ack run protocol; sequences NUM_PROGS back-to-back program runs on the DUT.
- Per run: drives a Start pulse, waits for the DUT's Ack (done) flag, then reports a cycle count per program.
- Sits between the test harness (or a future SoC host) and the processor top level, replacing hand-written testbench Start/Ack timing.

Parameters:
- NUM_PROGS, 3, number of programs run per Go request (1..15).
- START_CYCLES, 2, width of each DutStart pulse in Clk cycles (>=1).
- TIMEOUT, 16'd10000, max cycles in RUN before abort.
- CNT_W, 16, cycle counter width.

Ports:
- Clk  in  1  clock, posedge.
- Reset  in  1  synchronous, active-high.
- Go  in  1  single-cycle request to start a full sequence; sampled in IDLE only.
- DutStart  out  1  Start to processor.
- DutAck  in  1  Ack (done) from processor; combinational on DUT side, treated as asynchronous to phase.
- Busy  out  1  high from the cycle after Go is accepted until the return to IDLE.
- ProgIdx  out  4  index of the current or last-reported program (0-based).
- ResultValid  out  1  one-cycle strobe; CycleCount and ProgIdx are valid in that cycle.
- CycleCount  out  CNT_W  cycles spent in RUN for the reported program.
- Done  out  1  one-cycle strobe when all programs complete without timeout.
- TimeoutErr  out  1  sticky; set on abort, cleared by Reset or by an accepted Go.
- MaxCycles  out  CNT_W  see Optional Feature.

Behaviour:
- Reset is synchronous, active-high; clock is Clk.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset asserted mid-operation: next edge goes to IDLE with DutStart=0. No ResultValid or Done is emitted.
- States: IDLE, START, ARM, RUN, REPORT, FINISH.
- IDLE -> START on Go=1. Accepting Go clears ProgIdx to 0 and clears TimeoutErr. Go in any other state is ignored.
- START: DutStart=1 for exactly START_CYCLES cycles, then -> ARM with DutStart=0.
- ARM: waits for DutAck=0, so a stale Ack from the previous halt is ignored. The cycle counter starts at ARM entry.
  - DutAck=0 seen -> RUN.
  - Counter reaching TIMEOUT in ARM also aborts.
- RUN: first cycle with DutAck=1 -> REPORT.
  - Counter reaches TIMEOUT -> abort: TimeoutErr=1, no ResultValid, go to IDLE.
  - DutAck=1 in the same cycle the counter reaches TIMEOUT: Ack wins, normal REPORT.
- CycleCount = cycles from ARM entry to the cycle Ack is seen, inclusive of the Ack cycle. The counter saturates at all-ones and does not wrap.
- REPORT (1 cycle): ResultValid=1, CycleCount and ProgIdx held stable.
  - If ProgIdx==NUM_PROGS-1 -> FINISH.
  - Else ProgIdx+1 -> START.
- FINISH (1 cycle): Done=1, -> IDLE. ProgIdx and CycleCount hold their last values in IDLE.
- Busy=1 in every state except IDLE.
- Latency from Go to first DutStart: 1 cycle (DutStart is registered).

Optional Feature:
- Macro PROC_RUN_CTRL_MAXCYC_EN.
- Defined: MaxCycles holds the largest CycleCount reported since the last accepted Go. It updates in the REPORT cycle and clears to 0 on Go accept.
- Undefined: MaxCycles is tied to 0 and no compare logic is built.

Decomposition:
- Package run_ctrl_pkg holds:
  - state enum run_state_t (IDLE, START, ARM, RUN, REPORT, FINISH);
  - default CNT_W;
  - localparam for ProgIdx width (4).
- One natural sub-module, sat_counter (CNT_W, clear, enable, saturating). Used for the cycle count and reused for the START pulse-width count.

Test Plan:
- Go, DUT model raises Ack 20 cycles after ARM entry for each of 3 programs -> three ResultValid strobes with ProgIdx 0,1,2 and CycleCount=21 each; Done one cycle after the third REPORT; DutStart high exactly 2 cycles per program.
- Stale Ack: DutAck held 1 through START, drops 1 cycle into ARM, rises 10 cycles later -> CycleCount=12, not 1.
- Timeout: TIMEOUT=50, Ack never rises on program 1 -> TimeoutErr=1 at cycle 50 after ARM entry, no ResultValid for program 1, Done never asserted, Busy=0 next cycle.
- Reset asserted mid-RUN of program 1 -> next cycle all outputs 0, DutStart=0; a new Go restarts at ProgIdx 0.
- Go pulsed during RUN -> ignored; sequence finishes normally with exactly 3 ResultValid strobes.
- With PROC_RUN_CTRL_MAXCYC_EN defined, runs of 30/75/40 cycles -> MaxCycles=75 after Done; without the macro, MaxCycles=0 throughout.

Source files
------------

// File: rtl/proc_run_ctrl_pkg.sv
// Shared state encoding and widths for the program run controller.
package run_ctrl_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PIDX_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ARM,
        RUN,
        REPORT,
        FINISH
    } run_state_t;

endpackage

// File: rtl/proc_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Host-side Start/Ack sequencer: runs NUM_PROGS programs per Go and reports cycles per run.
// Optional MaxCycles tracking is built only when PROC_RUN_CTRL_MAXCYC_EN is defined.
module proc_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          NUM_PROGS    = 3,
    parameter int          START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 10000,
    parameter int          CNT_W        = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    output logic              DutStart,
    input  logic              DutAck,
    output logic              Busy,
    output logic [PIDX_W-1:0] ProgIdx,
    output logic              ResultValid,
    output logic [CNT_W-1:0]  CycleCount,
    output logic              Done,
    output logic              TimeoutErr,
    output logic [CNT_W-1:0]  MaxCycles
);

    // The count is inclusive of the current cycle, so the last legal cycle holds TIMEOUT-1.
    localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [PIDX_W-1:0] LAST_PROG  = PIDX_W'(NUM_PROGS - 1);

    run_state_t        state_q, state_d;
    logic [PIDX_W-1:0] prog_q, prog_d;
    logic              tmo_err_q, tmo_err_d;
    logic              dut_start_q, dut_start_d;
    logic [CNT_W-1:0]  cyc_cnt, pw_cnt;
    logic              tmo_hit;

    assign tmo_hit = (cyc_cnt >= TMO_LAST);

    always_comb begin
        state_d   = state_q;
        prog_d    = prog_q;
        tmo_err_d = tmo_err_q;
        case (state_q)
            IDLE: if (Go) begin
                state_d   = START;
                prog_d    = '0;
                tmo_err_d = 1'b0;
            end
            START: if (pw_cnt >= START_LAST) state_d = ARM;
            // A stale Ack left over from the previous halt must drop before RUN counts.
            ARM: begin
                if (!DutAck) state_d = RUN;
                else if (tmo_hit) begin
                    state_d   = IDLE;
                    tmo_err_d = 1'b1;
                end
            end
            RUN: begin
                if (DutAck) state_d = REPORT;
                else if (tmo_hit) begin
                    state_d   = IDLE;
                    tmo_err_d = 1'b1;
                end
            end
            REPORT: begin
                if (prog_q == LAST_PROG) state_d = FINISH;
                else begin
                    prog_d  = prog_q + PIDX_W'(1);
                    state_d = START;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dut_start_d = (state_d == START);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            prog_q      <= '0;
            tmo_err_q   <= 1'b0;
            dut_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_q      <= prog_d;
            tmo_err_q   <= tmo_err_d;
            dut_start_q <= dut_start_d;
        end
    end

    // Cycle count runs ARM..RUN and then holds, so it doubles as the reported value.
    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr_i ((state_d == ARM) && (state_q != ARM)),
        .en_i  ((state_q == ARM) || (state_q == RUN)),
        .cnt_o (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_pw_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr_i ((state_d == START) && (state_q != START)),
        .en_i  (state_q == START),
        .cnt_o (pw_cnt)
    );

    assign DutStart    = dut_start_q;
    assign Busy        = (state_q != IDLE);
    assign ProgIdx     = prog_q;
    assign ResultValid = (state_q == REPORT);
    assign CycleCount  = cyc_cnt;
    assign Done        = (state_q == FINISH);
    assign TimeoutErr  = tmo_err_q;

`ifdef PROC_RUN_CTRL_MAXCYC_EN
    logic [CNT_W-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if ((state_q == IDLE) && Go)
            max_d = '0;
        else if ((state_q == REPORT) && (cyc_cnt > max_q))
            max_d = cyc_cnt;
    end

    always_ff @(posedge Clk) begin
        if (Reset) max_q <= '0;
        else       max_q <= max_d;
    end

    assign MaxCycles = max_q;
`else
    assign MaxCycles = '0;
`endif

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: table-driven sequences plus timeout/reset corner cases.
`timescale 1ns/1ps
module tb_proc_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int NPROG = 3;
    localparam int SC    = 2;
    localparam int TMO   = 50;
    localparam int CW    = 16;

    logic              Clk = 1'b0;
    logic              Reset, Go, DutAck;
    logic              DutStart, Busy, ResultValid, Done, TimeoutErr;
    logic [PIDX_W-1:0] ProgIdx;
    logic [CW-1:0]     CycleCount, MaxCycles;

    logic              Go2, DutAck2;
    logic              DutStart2, Busy2, ResultValid2, Done2, TimeoutErr2;
    logic [PIDX_W-1:0] ProgIdx2;
    logic [CW-1:0]     CycleCount2, MaxCycles2;

    always #5 Clk = ~Clk;

    proc_run_ctrl #(.NUM_PROGS(NPROG), .START_CYCLES(SC), .TIMEOUT(TMO), .CNT_W(CW)) u_dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .DutStart(DutStart), .DutAck(DutAck),
        .Busy(Busy), .ProgIdx(ProgIdx), .ResultValid(ResultValid), .CycleCount(CycleCount),
        .Done(Done), .TimeoutErr(TimeoutErr), .MaxCycles(MaxCycles)
    );

    // Default timeout, for runs longer than the short-timeout instance allows.
    proc_run_ctrl #(.NUM_PROGS(NPROG), .START_CYCLES(SC), .CNT_W(CW)) u_big (
        .Clk(Clk), .Reset(Reset), .Go(Go2), .DutStart(DutStart2), .DutAck(DutAck2),
        .Busy(Busy2), .ProgIdx(ProgIdx2), .ResultValid(ResultValid2), .CycleCount(CycleCount2),
        .Done(Done2), .TimeoutErr(TimeoutErr2), .MaxCycles(MaxCycles2)
    );

    typedef struct {
        int idx;
        int cnt;
    } exp_t;

    typedef struct {
        int ack_at;   // ARM-relative cycle where Ack rises
        bit stale;    // Ack high through START and ARM cycle 0
        bit go_mid;   // spurious Go pulse during the run
        int exp_idx;
        int exp_cnt;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs [9];
    int   big_runs [3];
    int   checks = 0, errors = 0;
    int   rv_seen = 0, done_seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin : mon
        exp_t e;
        if (ResultValid) begin
            rv_seen++;
            if (sbq.size() == 0) chk("unexpected ResultValid", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("ProgIdx at ResultValid", ProgIdx, e.idx);
                chk("CycleCount at ResultValid", CycleCount, e.cnt);
            end
        end
        if (Done) done_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push_exp(input int idx, input int cnt);
        exp_t e;
        e.idx = idx;
        e.cnt = cnt;
        sbq.push_back(e);
    endtask

    task automatic pulse_go();
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
    endtask

    task automatic wait_arm();
        int n;
        n = 0;
        while (!DutStart && n < 20) begin @(negedge Clk); n++; end
        chk("DutStart rises", DutStart, 1);
        n = 0;
        while (DutStart && n < 20) begin @(negedge Clk); n++; end
        chk("DutStart width", n, SC);
    endtask

    // Returns at the negedge of the REPORT cycle.
    task automatic run_prog(input int ack_at, input bit stale, input bit go_mid);
        DutAck = stale;
        wait_arm();
        for (int k = 0; k <= ack_at; k++) begin
            if (k > 0) @(negedge Clk);
            DutAck = (stale && k == 0) || (k >= ack_at);
            Go     = go_mid && (k == 3);
        end
        @(negedge Clk);
        Go = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " DutStart"}, DutStart, 0);
        chk({tag, " Busy"}, Busy, 0);
        chk({tag, " ProgIdx"}, ProgIdx, 0);
        chk({tag, " ResultValid"}, ResultValid, 0);
        chk({tag, " CycleCount"}, CycleCount, 0);
        chk({tag, " Done"}, Done, 0);
        chk({tag, " TimeoutErr"}, TimeoutErr, 0);
        chk({tag, " MaxCycles"}, MaxCycles, 0);
    endtask

    task automatic run_seq(input int s);
        int rv0, d0, mx, exp_max, b;
        rv0 = rv_seen;
        d0  = done_seen;
        mx  = 0;
        for (int p = 0; p < NPROG; p++) begin
            b = s * NPROG + p;
            push_exp(vecs[b].exp_idx, vecs[b].exp_cnt);
            if (vecs[b].exp_cnt > mx) mx = vecs[b].exp_cnt;
        end
        pulse_go();
        chk("DutStart one cycle after Go", DutStart, 1);
        chk("Busy after Go", Busy, 1);
        chk("ProgIdx after Go", ProgIdx, 0);
        chk("TimeoutErr cleared by Go", TimeoutErr, 0);
        for (int p = 0; p < NPROG; p++) begin
            b = s * NPROG + p;
            run_prog(vecs[b].ack_at, vecs[b].stale, vecs[b].go_mid);
        end
        @(negedge Clk);
        chk("Done after last REPORT", Done, 1);
        chk("Busy in FINISH", Busy, 1);
        @(negedge Clk);
`ifdef PROC_RUN_CTRL_MAXCYC_EN
        exp_max = mx;
`else
        exp_max = 0;
`endif
        chk("Busy back in IDLE", Busy, 0);
        chk("ProgIdx held in IDLE", ProgIdx, NPROG - 1);
        chk("CycleCount held in IDLE", CycleCount, vecs[s * NPROG + NPROG - 1].exp_cnt);
        chk("MaxCycles after Done", MaxCycles, exp_max);
        chk("ResultValid count", rv_seen - rv0, NPROG);
        chk("Done count", done_seen - d0, 1);
        chk("scoreboard drained", sbq.size(), 0);
    endtask

    initial begin
        int rv0, d0, early, exp_big_max;
        Reset = 1'b1; Go = 1'b0; DutAck = 1'b0; Go2 = 1'b0; DutAck2 = 1'b0;

        vecs[0] = '{20, 1'b0, 1'b0, 0, 21};
        vecs[1] = '{20, 1'b0, 1'b1, 1, 21};
        vecs[2] = '{20, 1'b0, 1'b0, 2, 21};
        vecs[3] = '{11, 1'b1, 1'b0, 0, 12};
        vecs[4] = '{ 5, 1'b0, 1'b0, 1,  6};
        vecs[5] = '{ 3, 1'b1, 1'b0, 2,  4};
        vecs[6] = '{ 1, 1'b0, 1'b0, 0,  2};
        vecs[7] = '{ 2, 1'b1, 1'b0, 1,  3};
        vecs[8] = '{49, 1'b0, 1'b1, 2, 50};   // Ack on the last cycle before timeout
        big_runs[0] = 30; big_runs[1] = 75; big_runs[2] = 40;

        repeat (3) @(negedge Clk);
        chk_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);

        run_seq(0);
        run_seq(1);

        // Timeout: program 1 never acks.
        rv0 = rv_seen; d0 = done_seen; early = 0;
        push_exp(0, 6);
        pulse_go();
        run_prog(5, 1'b0, 1'b0);
        DutAck = 1'b0;
        wait_arm();
        for (int k = 0; k < TMO; k++) begin
            if (TimeoutErr || !Busy) early = 1;
            @(negedge Clk);
        end
        chk("no early abort", early, 0);
        chk("TimeoutErr at cycle 50", TimeoutErr, 1);
        chk("Busy low after abort", Busy, 0);
        repeat (3) @(negedge Clk);
        chk("TimeoutErr sticky", TimeoutErr, 1);
        chk("ResultValid count on timeout", rv_seen - rv0, 1);
        chk("no Done on timeout", done_seen - d0, 0);
        chk("scoreboard after timeout", sbq.size(), 0);

        run_seq(2);

        // Reset in the middle of program 1's RUN.
        rv0 = rv_seen; d0 = done_seen;
        push_exp(0, 21);
        pulse_go();
        run_prog(20, 1'b0, 1'b0);
        DutAck = 1'b0;
        wait_arm();
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk_zero("mid-run reset");
        Reset = 1'b0;
        chk("ResultValid count on reset", rv_seen - rv0, 1);
        chk("no Done on reset", done_seen - d0, 0);
        run_seq(0);

        // Long runs on the default-timeout instance.
        pulse_go2();
        for (int p = 0; p < NPROG; p++) begin
            DutAck2 = 1'b0;
            while (!DutStart2 && p < 100) begin @(negedge Clk); break_if_stuck(); end
            repeat (SC) @(negedge Clk);
            chk("big ARM entry", DutStart2, 0);
            repeat (big_runs[p] - 1) @(negedge Clk);
            DutAck2 = 1'b1;
            @(negedge Clk);
            chk("big ResultValid", ResultValid2, 1);
            chk("big ProgIdx", ProgIdx2, p);
            chk("big CycleCount", CycleCount2, big_runs[p]);
        end
        @(negedge Clk);
        chk("big Done", Done2, 1);
        @(negedge Clk);
`ifdef PROC_RUN_CTRL_MAXCYC_EN
        exp_big_max = 75;
`else
        exp_big_max = 0;
`endif
        chk("big MaxCycles", MaxCycles2, exp_big_max);
        chk("big Busy idle", Busy2, 0);
        chk("big TimeoutErr", TimeoutErr2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic pulse_go2();
        Go2 = 1'b1;
        @(negedge Clk);
        Go2 = 1'b0;
    endtask

    int stuck_cnt = 0;
    task automatic break_if_stuck();
        stuck_cnt++;
        if (stuck_cnt > 200) begin
            $display("FAIL big DutStart never rose");
            $fatal(1);
        end
    endtask

endmodule
